// File: rtl/pc_branch_unit.sv
// +----------------------------------------------------------------------+
// | pc_branch_unit: PC register, next-PC select, misaligned-target trap   |
// | Optional stats counters via BRANCH_STATS_EN.  Rev 1.0                 |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              is_branch,
  input  logic              is_jal,
  input  logic              is_jalr,
  input  logic [31:0]       cmp_result,
  input  logic [31:0]       imm,
  input  logic [31:0]       rs1,
  input  logic              clear_trap,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       next_pc,
  output logic              taken,
  output logic              misalign,
  output logic [31:0]       trap_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  br_taken_count
`endif
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        mis_tgt;
  logic        unused_cmp_hi;

  assign unused_cmp_hi = ^cmp_result[31:1];

  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    jalr_sum   = rs1 + imm;
    target     = is_jalr ? {jalr_sum[31:1], 1'b0} : (pc_q + imm);
    taken      = (state_q == ST_RUN) &&
                 (is_jalr || is_jal || (is_branch && cmp_result[0]));
    mis_tgt    = taken && (target[1:0] != 2'b00);
    next_pc    = pc_plus4;
    state_d    = state_q;
    misalign_d = misalign_q;
    trap_pc_d  = trap_pc_q;

    if (state_q == ST_RUN) begin
      if (mis_tgt) begin
        next_pc    = TRAP_VEC;
        state_d    = ST_TRAP;
        misalign_d = 1'b1;
        trap_pc_d  = pc_q;
      end else if (taken) begin
        next_pc = target;
      end
    end else begin
      // Leaving the trap resumes at the vector itself, so pc is held here.
      next_pc = pc_q;
      if (clear_trap) begin
        state_d    = ST_RUN;
        misalign_d = 1'b0;
      end
    end

    pc_d = next_pc;
    if (stall) begin
      pc_d       = pc_q;
      state_d    = state_q;
      misalign_d = misalign_q;
      trap_pc_d  = trap_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      trap_pc_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      trap_pc_q  <= trap_pc_d;
    end
  end

  assign pc       = pc_q;
  assign misalign = misalign_q;
  assign trap_pc  = trap_pc_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] br_taken_count_q, br_taken_count_d;

  // Saturating counters; a trapping branch still counts as retired and taken.
  always_comb begin
    br_count_d       = br_count_q;
    br_taken_count_d = br_taken_count_q;
    if ((state_q == ST_RUN) && !stall && is_branch) begin
      if (br_count_q != {CNT_W{1'b1}}) begin
        br_count_d = br_count_q + 1'b1;
      end
      if (cmp_result[0] && (br_taken_count_q != {CNT_W{1'b1}})) begin
        br_taken_count_d = br_taken_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q       <= '0;
      br_taken_count_q <= '0;
    end else begin
      br_count_q       <= br_count_d;
      br_taken_count_q <= br_taken_count_d;
    end
  end

  assign br_count       = br_count_q;
  assign br_taken_count = br_taken_count_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit with an expected-value scoreboard queue.
`default_nettype none

module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, is_branch, is_jal, is_jalr, clear_trap;
  logic [31:0] cmp_result, imm, rs1;
  logic [31:0] pc, pc_plus4, next_pc, trap_pc;
  logic        taken, misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, br_taken_count;
  logic [31:0] s_pc, s_pc_plus4, s_next_pc, s_trap_pc;
  logic        s_taken, s_misalign;
  logic [1:0]  s_br_count, s_br_taken_count;
`endif

  always #5 clk = ~clk;

  pc_branch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .is_branch(is_branch), .is_jal(is_jal),
    .is_jalr(is_jalr), .cmp_result(cmp_result), .imm(imm), .rs1(rs1),
    .clear_trap(clear_trap), .pc(pc), .pc_plus4(pc_plus4), .next_pc(next_pc),
    .taken(taken), .misalign(misalign), .trap_pc(trap_pc)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .br_taken_count(br_taken_count)
`endif
  );

`ifdef BRANCH_STATS_EN
  pc_branch_unit #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .is_branch(is_branch), .is_jal(is_jal),
    .is_jalr(is_jalr), .cmp_result(cmp_result), .imm(imm), .rs1(rs1),
    .clear_trap(clear_trap), .pc(s_pc), .pc_plus4(s_pc_plus4), .next_pc(s_next_pc),
    .taken(s_taken), .misalign(s_misalign), .trap_pc(s_trap_pc),
    .br_count(s_br_count), .br_taken_count(s_br_taken_count)
  );
`endif

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int errors = 0;
  int checks = 0;
  int exp_br = 0;
  int exp_tk = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return pc;
      1: return pc_plus4;
      2: return next_pc;
      3: return {31'b0, taken};
      4: return {31'b0, misalign};
      5: return trap_pc;
`ifdef BRANCH_STATS_EN
      6: return br_count;
      7: return br_taken_count;
      8: return {30'b0, s_br_count};
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    is_branch = 0; is_jal = 0; is_jalr = 0; cmp_result = 0;
    imm = 0; rs1 = 0; clear_trap = 0; stall = 0;
  endtask

  task automatic expect_counts(input string tag);
`ifdef BRANCH_STATS_EN
    expect_val({tag, "_brc"}, 6, exp_br);
    expect_val({tag, "_tkc"}, 7, exp_tk);
`else
    if (tag.len() < 0) exp_br = 0;
`endif
  endtask

  task automatic branch_step(input logic c, input logic [31:0] im, input logic stl);
    is_branch = 1; cmp_result = {31'b0, c}; imm = im; stall = stl;
    if (!stl) begin
      exp_br++;
      if (c) exp_tk++;
    end
    step();
  endtask

  initial begin
    rst = 1; idle();
    step();
    rst = 0;
    expect_val("rst_pc", 0, 32'h0);
    expect_val("rst_mis", 4, 32'h0);
    expect_val("rst_tpc", 5, 32'h0);
    expect_counts("rst");
    drain();
    step(); expect_val("seq4", 0, 32'h4); drain();
    step(); expect_val("seq8", 0, 32'h8); drain();
    step(); expect_val("seq12", 0, 32'hC); expect_val("seq_mis", 4, 0); drain();
    step(); expect_val("seq16", 0, 32'h10); drain();

    // not-taken branch at 0x10
    is_branch = 1; imm = 32'h20; cmp_result = 0; #1;
    expect_val("nt_taken", 3, 0); expect_val("nt_next", 2, 32'h14); drain();
    branch_step(0, 32'h20, 0);
    expect_val("nt_pc", 0, 32'h14); drain();

    // taken branch at 0x14
    cmp_result = 1; #1;
    expect_val("br_taken", 3, 1); expect_val("br_next", 2, 32'h34); drain();
    branch_step(1, 32'h20, 0);
    expect_val("br_pc", 0, 32'h34); drain();

    // not-taken branch with misaligned target does not trap
    branch_step(0, 32'h6, 0);
    expect_val("ntmis_pc", 0, 32'h38); expect_val("ntmis_mis", 4, 0);
    expect_counts("ntmis"); drain();

    idle(); is_jal = 1; imm = 32'h8; step();
    expect_val("jal_pc", 0, 32'h40); drain();

    // jalr beats jal; bit0 of the sum is cleared
    idle(); is_jalr = 1; is_jal = 1; rs1 = 32'h1001; imm = 32'h4; #1;
    expect_val("jalr_p4", 1, 32'h44); expect_val("jalr_next", 2, 32'h1004);
    expect_val("jalr_taken", 3, 1); drain();
    step();
    expect_val("jalr_pc", 0, 32'h1004); drain();

    idle(); is_jal = 1; imm = 32'hFFFF_F07C; step();
    expect_val("jal_back", 0, 32'h80); drain();

    // misaligned jal target traps
    imm = 32'h6; #1;
    expect_val("trap_next", 2, 32'h100); drain();
    step();
    expect_val("trap_pc", 0, 32'h100); expect_val("trap_mis", 4, 1);
    expect_val("trap_tpc", 5, 32'h80); drain();
    for (int i = 0; i < 3; i++) begin
      step();
      expect_val("trap_hold", 0, 32'h100); expect_val("trap_tk0", 3, 0); drain();
    end
    stall = 1; clear_trap = 1; step();
    expect_val("stclr_mis", 4, 1); expect_val("stclr_pc", 0, 32'h100); drain();
    stall = 0; step();
    expect_val("clr_mis", 4, 0); expect_val("clr_pc", 0, 32'h100);
    expect_val("clr_tpc", 5, 32'h80); drain();
    idle(); step();
    expect_val("resume", 0, 32'h104); drain();

    // stalled taken branch holds everything
    branch_step(1, 32'h10, 1);
    expect_val("stall_pc", 0, 32'h104); expect_counts("stall"); drain();
    branch_step(1, 32'h10, 0);
    expect_val("unstall_pc", 0, 32'h114); expect_counts("unstall"); drain();

    // trapping branch still counts, then reset wins over clear_trap
    branch_step(1, 32'h2, 0);
    expect_val("btrap_mis", 4, 1); expect_val("btrap_tpc", 5, 32'h114);
    expect_counts("btrap"); drain();
    idle(); rst = 1; clear_trap = 1; step();
    rst = 0; clear_trap = 0; exp_br = 0; exp_tk = 0;
    expect_val("trst_pc", 0, 32'h0); expect_val("trst_mis", 4, 0);
    expect_val("trst_tpc", 5, 32'h0); expect_counts("trst"); drain();

    // five retired branches, three taken, one extra stalled cycle
    branch_step(1, 32'h8, 0);
    branch_step(0, 32'h8, 0);
    branch_step(1, 32'h8, 1);
    branch_step(1, 32'h8, 0);
    branch_step(0, 32'h8, 0);
    branch_step(1, 32'h8, 0);
    expect_counts("stats");
`ifdef BRANCH_STATS_EN
    expect_val("sat_brc", 8, 32'h3);
`endif
    drain();

    // silent wrap-around
    idle(); is_jalr = 1; rs1 = 32'hFFFF_FFF8; step();
    expect_val("wrap_a", 0, 32'hFFFF_FFF8); drain();
    idle(); step();
    expect_val("wrap_p4", 1, 32'h0); drain();
    step();
    expect_val("wrap_pc", 0, 32'h0); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter register and next-PC selection for the single-cycle RISC-V core. Consumes the 32-bit zero-extended compare result from the branch comparator, together with decoder control and immediates. It decides branch/jump redirection and updates the PC every unstalled cycle. Misaligned taken targets trap to a fixed vector and halt the PC until software/testbench clears the trap.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded when a misaligned target is detected
- CNT_W, 32, width of statistics counters (used only with BRANCH_STATS_EN)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and all state this cycle
- is_branch  in  1  current instruction is a conditional branch
- is_jal  in  1  current instruction is JAL
- is_jalr  in  1  current instruction is JALR
- cmp_result  in  32  comparator output; only bit 0 used (1 = condition true)
- imm  in  32  sign-extended immediate
- rs1  in  32  rs1 operand (JALR base)
- clear_trap  in  1  leave TRAP state
- pc  out  32  registered current PC
- pc_plus4  out  32  pc + 4 (link value), combinational
- next_pc  out  32  PC to be loaded at next edge if not stalled, combinational
- taken  out  1  redirect taken this cycle, combinational
- misalign  out  1  registered, high while in TRAP
- trap_pc  out  32  registered PC of the offending instruction
- br_count  out  CNT_W  branches retired (only with BRANCH_STATS_EN)
- br_taken_count  out  CNT_W  taken branches retired (only with BRANCH_STATS_EN)

## Operation
- States: RUN, TRAP. Reset state RUN.
- Reset values: pc=RESET_PC, misalign=0, trap_pc=0, counters=0.
- taken = is_jalr | is_jal | (is_branch & cmp_result[0]); forced 0 in TRAP.
- Target priority when several is_* are high: jalr > jal > branch.
  - jalr: target = (rs1 + imm) & ~32'h1.
  - jal/branch: target = pc + imm.
- All adds modulo 2^32; wrap-around is silent (0xFFFF_FFFC + 4 = 0).
- RUN, no stall:
  - If taken and target[1:0] != 0: pc <= TRAP_VEC, trap_pc <= pc, misalign <= 1, go TRAP.
  - Otherwise pc <= taken ? target : pc_plus4.
- next_pc reflects exactly the value the above would load (TRAP_VEC on misalign).
- TRAP: pc held at TRAP_VEC; is_* ignored. clear_trap (not stalled) -> RUN, misalign <= 0, trap_pc retained; execution resumes at TRAP_VEC.
- Misaligned target with bit1 clear but bit0 set is only possible for branch/jal; jalr clears bit0 before the check.
- Not-taken branch with misaligned target: no trap.

## Timing
- pc updates on the rising edge; taken/next_pc/pc_plus4 are valid in the same cycle as the inputs.
- Latency: decision to pc visible = 1 cycle.
- Priority: rst > stall > trap/redirect > sequential.
- stall high: pc, state, misalign, trap_pc and counters all hold; clear_trap is ignored while stalled.
- rst mid-TRAP: returns to RUN at RESET_PC, misalign=0, trap_pc=0.
- rst and clear_trap together: reset wins.

## Configuration
- BRANCH_STATS_EN defined:
  - br_count and br_taken_count ports exist.
  - In RUN, unstalled, not in rst: is_branch increments br_count; is_branch & cmp_result[0] also increments br_taken_count.
  - A branch that traps still counts as retired and taken.
  - Both counters saturate at all-ones and clear only on rst.
- BRANCH_STATS_EN undefined: ports and counter logic absent; behaviour otherwise identical.

## Test plan
- Reset/sequential: rst 1 cycle, no control -> pc=0, then 4, 8, 12; misalign=0.
- Branch: pc=0x10, is_branch=1, imm=0x20; cmp_result=1 -> pc=0x30, taken=1; cmp_result=0 -> pc=0x14, taken=0.
- JALR priority/alignment: pc=0x40, is_jalr=1, is_jal=1, rs1=0x1001, imm=0x4 -> pc=0x1004, pc_plus4=0x44 during the jump cycle.
- Misaligned trap: pc=0x80, is_jal=1, imm=0x6 -> pc=0x100, misalign=1, trap_pc=0x80. Hold 3 cycles with pc=0x100; clear_trap -> misalign=0, pc=0x104 next.
- Stall and reset: stall during a taken branch -> pc unchanged, counters unchanged. rst asserted in TRAP -> pc=0, misalign=0.
- Stats (BRANCH_STATS_EN): 5 branches, 3 with cmp_result=1, one stalled extra cycle -> br_count=5, br_taken_count=3. With CNT_W=2, 5 branches -> br_count saturates at 3.
